matrix_scan_controller: RTL and testbench

MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

---
 rtl/matrix_scan_controller.sv | 142 ++++++++++++++
 tb/tb_matrix_scan_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_controller.sv
// 3-column LED matrix scanner with double-buffered frames: a new frame is only promoted to the
// displayed image at a frame boundary (or while idle), so a partial image is never shown.
module matrix_scan_controller #(
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [20:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [2:0]  col,
  output logic [6:0]  row,
  output logic        frame_done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic [BW-1:0] blank_cnt, blank_nxt;
  logic [20:0]   active, shadow;
  logic          shadow_full;
  logic          load_active;
  state_t        after_drive;

  assign frame_ready = ~shadow_full;

  // With no blanking interval the scan goes straight from column to column.
  assign after_drive = (BLANK == 0) ? ST_DRIVE : ST_BLANK;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    dwell_nxt   = dwell_cnt;
    blank_nxt   = blank_cnt;
    load_active = 1'b0;
    col         = 3'b000;
    row         = 7'd0;
    frame_done  = 1'b0;

    case (state)
      ST_IDLE: begin
        idx_nxt     = 2'd0;
        dwell_nxt   = '0;
        blank_nxt   = '0;
        load_active = shadow_full;
        if (enable) begin
          state_nxt = after_drive;
        end
      end

      ST_BLANK: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          idx_nxt   = 2'd0;
          dwell_nxt = '0;
          blank_nxt = '0;
        end else if (blank_cnt == BLANK_LAST) begin
          blank_nxt = '0;
          state_nxt = ST_DRIVE;
        end else begin
          blank_nxt = blank_cnt + 1'b1;
        end
      end

      ST_DRIVE: begin
        col = 3'b001 << idx;
        case (idx)
          2'd0:    row = active[6:0];
          2'd1:    row = active[13:7];
          2'd2:    row = active[20:14];
          default: row = 7'd0;
        endcase

        if (!enable) begin
          state_nxt = ST_IDLE;
          idx_nxt   = 2'd0;
          dwell_nxt = '0;
          blank_nxt = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          state_nxt = after_drive;
          if (idx == 2'd2) begin
            // Frame boundary: the only point mid-scan where the displayed image may change.
            idx_nxt     = 2'd0;
            frame_done  = 1'b1;
            load_active = shadow_full;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = 2'd0;
        dwell_nxt = '0;
        blank_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= 2'd0;
      dwell_cnt   <= '0;
      blank_cnt   <= '0;
      active      <= 21'd0;
      shadow      <= 21'd0;
      shadow_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      dwell_cnt <= dwell_nxt;
      blank_cnt <= blank_nxt;
      // Promotion and acceptance are mutually exclusive: one needs shadow_full, the other its absence.
      if (load_active) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end else if (frame_valid && !shadow_full) begin
        shadow      <= frame_data;
        shadow_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: scan timing, tear-free frame swap, backpressure, disable and reset.
// Expected per-cycle column/row/done values are queued when stimulus is applied and popped each cycle.
module tb_matrix_scan_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        enable_a, valid_a, ready_a, done_a;
  logic [20:0] data_a;
  logic [2:0]  col_a;
  logic [6:0]  row_a;
  logic        enable_b, valid_b, ready_b, done_b;
  logic [20:0] data_b;
  logic [2:0]  col_b;
  logic [6:0]  row_b;

  matrix_scan_controller #(.DWELL(4), .BLANK(2)) u_dut_a (
    .clock(clock), .reset(reset), .enable(enable_a),
    .frame_data(data_a), .frame_valid(valid_a), .frame_ready(ready_a),
    .col(col_a), .row(row_a), .frame_done(done_a)
  );

  matrix_scan_controller #(.DWELL(1), .BLANK(0)) u_dut_b (
    .clock(clock), .reset(reset), .enable(enable_b),
    .frame_data(data_b), .frame_valid(valid_b), .frame_ready(ready_b),
    .col(col_b), .row(row_b), .frame_done(done_b)
  );

  typedef struct packed {
    logic [2:0] col;
    logic [6:0] row;
    logic       done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [20:0] IMG_ONES = 21'h1FFFFF;
  localparam logic [20:0] IMG_X    = 21'h0F1E2D;
  localparam logic [20:0] IMG_Y    = 21'h15A3C6;
  localparam logic [20:0] IMG_Z    = 21'h0A5C3E;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Queue one full frame: per column, nb dark cycles then nd driven cycles; done on the very last.
  task automatic push_frame(input bit sel, input logic [20:0] img, input int nb, input int nd);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < nb; i++) begin
        e = '0;
        if (sel) q_b.push_back(e); else q_a.push_back(e);
      end
      for (int i = 0; i < nd; i++) begin
        e.col  = 3'(1 << k);
        e.row  = img[7*k +: 7];
        e.done = (k == 2) && (i == nd - 1);
        if (sel) q_b.push_back(e); else q_a.push_back(e);
      end
    end
  endtask

  task automatic flush_idle_a(input int n);
    q_a.delete();
    for (int i = 0; i < n; i++) q_a.push_back(exp_t'(0));
  endtask

  task automatic tick_a(input int c);
    exp_t e;
    @(negedge clock);
    chk($sformatf("a_q_avail@%0d", c), 32'(q_a.size() > 0), 32'd1);
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk($sformatf("a_col@%0d", c), 32'(col_a), 32'(e.col));
      chk($sformatf("a_row@%0d", c), 32'(row_a), 32'(e.row));
      chk($sformatf("a_done@%0d", c), 32'(done_a), 32'(e.done));
    end
  endtask

  task automatic tick_b(input int c);
    exp_t e;
    @(negedge clock);
    chk($sformatf("b_q_avail@%0d", c), 32'(q_b.size() > 0), 32'd1);
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk($sformatf("b_col@%0d", c), 32'(col_b), 32'(e.col));
      chk($sformatf("b_row@%0d", c), 32'(row_b), 32'(e.row));
      chk($sformatf("b_done@%0d", c), 32'(done_b), 32'(e.done));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    enable_a = 1'b0; valid_a = 1'b0; data_a = 21'd0;
    enable_b = 1'b0; valid_b = 1'b0; data_b = 21'd0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_col_a", 32'(col_a), 32'd0);
    chk("rst_row_a", 32'(row_a), 32'd0);
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_col_b", 32'(col_b), 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    reset = 1'b0;

    // Load the all-ones image while idle, then start scanning.
    valid_a = 1'b1; data_a = IMG_ONES;
    @(negedge clock);
    valid_a = 1'b0;
    chk("a_ready_after_load", 32'(ready_a), 32'd0);
    @(negedge clock);
    chk("a_ready_idle_promote", 32'(ready_a), 32'd1);
    enable_a = 1'b1;
    push_frame(1'b0, IMG_ONES, 2, 4);

    for (int c = 0; c <= 100; c++) begin
      tick_a(c);
      case (c)
        9: begin
          chk("a_ready_idx1", 32'(ready_a), 32'd1);
          valid_a = 1'b1; data_a = 21'd0;
          push_frame(1'b0, 21'd0, 2, 4);
        end
        10: begin
          valid_a = 1'b0;
          chk("a_ready_held_full", 32'(ready_a), 32'd0);
        end
        17: chk("a_ready_at_done", 32'(ready_a), 32'd0);
        18: chk("a_ready_after_done", 32'(ready_a), 32'd1);
        20: begin
          chk("a_ready_first_b2b", 32'(ready_a), 32'd1);
          valid_a = 1'b1; data_a = IMG_X;
          push_frame(1'b0, IMG_X, 2, 4);
        end
        21: begin
          chk("a_ready_second_b2b", 32'(ready_a), 32'd0);
          data_a = IMG_Y;
          push_frame(1'b0, IMG_Y, 2, 4);
        end
        35: chk("a_ready_hold_at_done", 32'(ready_a), 32'd0);
        36: chk("a_ready_boundary", 32'(ready_a), 32'd1);
        37: begin
          chk("a_ready_second_taken", 32'(ready_a), 32'd0);
          valid_a = 1'b0;
        end
        69: begin
          enable_a = 1'b0;
          flush_idle_a(4);
        end
        73: begin
          enable_a = 1'b1;
          push_frame(1'b0, IMG_Y, 2, 4);
        end
        91: push_frame(1'b0, IMG_Y, 2, 4);
        100: begin
          reset = 1'b1; enable_a = 1'b0;
          valid_a = 1'b1; data_a = IMG_ONES;
        end
        default: ;
      endcase
    end

    q_a.delete();
    @(negedge clock);
    chk("a_rst_col", 32'(col_a), 32'd0);
    chk("a_rst_row", 32'(row_a), 32'd0);
    chk("a_rst_ready", 32'(ready_a), 32'd1);
    chk("a_rst_done", 32'(done_a), 32'd0);
    reset = 1'b0; valid_a = 1'b0;
    @(negedge clock);
    chk("a_rst_not_accepted", 32'(ready_a), 32'd1);

    // No blanking, one-cycle dwell: columns step every cycle with no dark gap.
    valid_b = 1'b1; data_b = IMG_Z;
    @(negedge clock);
    valid_b = 1'b0;
    @(negedge clock);
    enable_b = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(1'b1, IMG_Z, 0, 1);
    for (int c = 0; c < 9; c++) tick_b(c);
    enable_b = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
